sram_arbiter: RTL and testbench

Two-to-one arbiter sharing one SRAM-like memory port between the IF-stage instruction port and the MEM-stage data port. It sits between the CPU core and the single downstream SRAM-like bus, which leads to the cache or the AXI bridge. It arbitrates each address phase and records the grant order in an in-order tag FIFO. It uses that record to steer each returning `data_ok` back to the requester that issued the transaction.

---
 rtl/sram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one SRAM-like downstream port between the IF-stage instruction
//   port (inst_sram_*) and the MEM-stage data port (data_sram_*).
//   Each accepted address phase is recorded in an in-order tag FIFO.
//   The tag FIFO steers each returning mem_data_ok back to the requester
//   that issued the transaction.
//
// Parameters
//   DEPTH  max outstanding accepted-but-unreturned transactions (power of 2, >= 2)
//   PTR_W  log2(DEPTH)
//
// Ports
//   clk, resetn                     clock, synchronous active-low reset
//   inst_sram_req/wr/size/wstrb/addr/wdata   instruction request fields
//   inst_sram_addr_ok/data_ok/rdata          instruction handshakes + data
//   data_sram_req/wr/size/wstrb/addr/wdata   data request fields
//   data_sram_addr_ok/data_ok/rdata          data handshakes + data
//   mem_req/wr/size/wstrb/addr/wdata         shared downstream request
//   mem_addr_ok/mem_data_ok/mem_rdata        downstream handshakes + data
//
// Build option
//   ARB_ROUND_ROBIN_EN  defined: round-robin on conflict.
//                       undefined: fixed priority, data over inst.
module sram_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  src_t             sel;
  logic             sel_req;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  src_t             tag_mem [DEPTH];
  src_t             head;

  // ---------------------------------------------------------------- grant
`ifdef ARB_ROUND_ROBIN_EN
  src_t last_grant;

  // Only conflicts that actually got accepted move the round-robin pointer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant <= SRC_INST;
    end else if (push && inst_sram_req && data_sram_req) begin
      last_grant <= sel;
    end
  end

  always_comb begin
    sel = SRC_INST;
    if (inst_sram_req && data_sram_req) begin
      sel = (last_grant == SRC_INST) ? SRC_DATA : SRC_INST;
    end else if (data_sram_req) begin
      sel = SRC_DATA;
    end
  end
`else
  always_comb begin
    sel = SRC_INST;
    if (data_sram_req) begin
      sel = SRC_DATA;
    end
  end
`endif

  // ---------------------------------------------------------------- request mux
  always_comb begin
    if (sel == SRC_DATA) begin
      sel_req   = data_sram_req;
      mem_wr    = data_sram_wr;
      mem_size  = data_sram_size;
      mem_wstrb = data_sram_wstrb;
      mem_addr  = data_sram_addr;
      mem_wdata = data_sram_wdata;
    end else begin
      sel_req   = inst_sram_req;
      mem_wr    = inst_sram_wr;
      mem_size  = inst_sram_size;
      mem_wstrb = inst_sram_wstrb;
      mem_addr  = inst_sram_addr;
      mem_wdata = inst_sram_wdata;
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = tag_mem[rd_ptr];

  // resetn gating keeps every handshake low while reset is applied.
  assign mem_req = resetn && sel_req && !full;
  assign push    = mem_req && mem_addr_ok;
  assign pop     = resetn && mem_data_ok && !empty;

  assign inst_sram_addr_ok = mem_addr_ok && mem_req && (sel == SRC_INST);
  assign data_sram_addr_ok = mem_addr_ok && mem_req && (sel == SRC_DATA);

  assign inst_sram_data_ok = pop && (head == SRC_INST);
  assign data_sram_data_ok = pop && (head == SRC_DATA);

  assign inst_sram_rdata = mem_rdata;
  assign data_sram_rdata = mem_rdata;

  // ---------------------------------------------------------------- tag FIFO
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (default DEPTH=4).
// Inputs change at the falling edge; outputs are checked 1 ns later.
module tb_sram_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int unsigned total = 0;
  int unsigned bad   = 0;

  sram_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    inst_sram_req = 1'b0;
    data_sram_req = 1'b0;
    mem_addr_ok   = 1'b0;
    mem_data_ok   = 1'b0;
  endtask

  // Advance to the next falling edge (one rising edge in between).
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic probe();
    #1;
  endtask

  localparam logic [31:0] INST_A = 32'hbfc0_0000;
  localparam logic [31:0] DATA_A = 32'h8000_1000;

  logic exp_data [4];
  int   n_conf;

  initial begin
    resetn          = 1'b0;
    inst_sram_wr    = 1'b0;
    inst_sram_size  = 2'd2;
    inst_sram_wstrb = 4'h0;
    inst_sram_addr  = INST_A;
    inst_sram_wdata = 32'h0;
    data_sram_wr    = 1'b1;
    data_sram_size  = 2'd1;
    data_sram_wstrb = 4'h3;
    data_sram_addr  = DATA_A;
    data_sram_wdata = 32'h1234_5678;
    mem_rdata       = 32'h0;
    idle();

    // ---- reset: outputs held low even with activity on the inputs
    next_cycle();
    inst_sram_req = 1'b1;
    data_sram_req = 1'b1;
    mem_addr_ok   = 1'b1;
    mem_data_ok   = 1'b1;
    mem_rdata     = 32'hdead_beef;
    probe();
    check("rst_mem_req",   32'(mem_req), 32'd0);
    check("rst_addr_ok",   32'({inst_sram_addr_ok, data_sram_addr_ok}), 32'd0);
    check("rst_data_ok",   32'({inst_sram_data_ok, data_sram_data_ok}), 32'd0);
    check("rst_rdata",     data_sram_rdata, 32'hdead_beef);
    check("rst_count",     32'(dut.count), 32'd0);
    next_cycle();
    idle();
    resetn = 1'b1;
    probe();
    check("post_rst_mem_req", 32'(mem_req), 32'd0);

    // ---- single fetch
    next_cycle();
    inst_sram_req = 1'b1;
    mem_addr_ok   = 1'b1;
    probe();
    check("fetch_mem_req",   32'(mem_req), 32'd1);
    check("fetch_mem_addr",  mem_addr, INST_A);
    check("fetch_mem_size",  32'(mem_size), 32'd2);
    check("fetch_i_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    check("fetch_d_addr_ok", 32'(data_sram_addr_ok), 32'd0);
    next_cycle();
    idle();
    probe();
    check("fetch_c1_data_ok", 32'({inst_sram_data_ok, data_sram_data_ok}), 32'd0);
    check("fetch_c1_count",   32'(dut.count), 32'd1);
    next_cycle();
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h2408_0001;
    probe();
    check("fetch_i_data_ok", 32'(inst_sram_data_ok), 32'd1);
    check("fetch_d_data_ok", 32'(data_sram_data_ok), 32'd0);
    check("fetch_rdata",     inst_sram_rdata, 32'h2408_0001);
    next_cycle();
    idle();
    probe();
    check("fetch_count", 32'(dut.count), 32'd0);

    // ---- conflict: both requesting every cycle
`ifdef ARB_ROUND_ROBIN_EN
    n_conf = 4;
    exp_data[0] = 1'b1; exp_data[1] = 1'b0; exp_data[2] = 1'b1; exp_data[3] = 1'b0;
`else
    n_conf = 3;
    exp_data[0] = 1'b1; exp_data[1] = 1'b1; exp_data[2] = 1'b1; exp_data[3] = 1'b1;
`endif
    for (int i = 0; i < n_conf; i++) begin
      next_cycle();
      inst_sram_req = 1'b1;
      data_sram_req = 1'b1;
      mem_addr_ok   = 1'b1;
      probe();
      check($sformatf("conf%0d_mem_addr", i), mem_addr, exp_data[i] ? DATA_A : INST_A);
      check($sformatf("conf%0d_mem_wr", i), 32'(mem_wr), 32'(exp_data[i]));
      check($sformatf("conf%0d_i_addr_ok", i), 32'(inst_sram_addr_ok), 32'(!exp_data[i]));
      check($sformatf("conf%0d_d_addr_ok", i), 32'(data_sram_addr_ok), 32'(exp_data[i]));
    end
    for (int i = 0; i < n_conf; i++) begin
      next_cycle();
      idle();
      mem_data_ok = 1'b1;
      mem_rdata   = 32'(i + 100);
      probe();
      check($sformatf("conf_ret%0d_i", i), 32'(inst_sram_data_ok), 32'(!exp_data[i]));
      check($sformatf("conf_ret%0d_d", i), 32'(data_sram_data_ok), 32'(exp_data[i]));
    end
    next_cycle();
    idle();
    probe();
    check("conf_count", 32'(dut.count), 32'd0);

    // ---- full: 4 accepted, 5th blocked, pop does not unblock same cycle
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      inst_sram_req = 1'b1;
      mem_addr_ok   = 1'b1;
      probe();
      check($sformatf("fill%0d_addr_ok", i), 32'(inst_sram_addr_ok), 32'd1);
    end
    next_cycle();
    probe();
    check("full_count",   32'(dut.count), 32'd4);
    check("full_mem_req", 32'(mem_req), 32'd0);
    check("full_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    next_cycle();
    mem_data_ok = 1'b1;
    probe();
    check("full_pop_mem_req", 32'(mem_req), 32'd0);
    check("full_pop_data_ok", 32'(inst_sram_data_ok), 32'd1);
    next_cycle();
    mem_data_ok = 1'b0;
    probe();
    check("after_pop_mem_req", 32'(mem_req), 32'd1);
    check("after_pop_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    next_cycle();
    idle();
    probe();
    check("refill_count", 32'(dut.count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      mem_data_ok = 1'b1;
      probe();
      check($sformatf("drain%0d_data_ok", i), 32'(inst_sram_data_ok), 32'd1);
    end
    next_cycle();
    idle();
    probe();
    check("drain_count", 32'(dut.count), 32'd0);

    // ---- interleaved: inst, data, inst
    exp_data[0] = 1'b0; exp_data[1] = 1'b1; exp_data[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle();
      inst_sram_req = !exp_data[i];
      data_sram_req = exp_data[i];
      mem_addr_ok   = 1'b1;
      probe();
      check($sformatf("il%0d_mem_addr", i), mem_addr, exp_data[i] ? DATA_A : INST_A);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      idle();
      mem_data_ok = 1'b1;
      probe();
      check($sformatf("il_ret%0d_i", i), 32'(inst_sram_data_ok), 32'(!exp_data[i]));
      check($sformatf("il_ret%0d_d", i), 32'(data_sram_data_ok), 32'(exp_data[i]));
    end
    next_cycle();
    idle();
    probe();
    check("il_count", 32'(dut.count), 32'd0);

    // ---- reset mid-flight, late returns dropped
    next_cycle();
    inst_sram_req = 1'b1;
    mem_addr_ok   = 1'b1;
    next_cycle();
    idle();
    data_sram_req = 1'b1;
    mem_addr_ok   = 1'b1;
    next_cycle();
    idle();
    probe();
    check("mid_count", 32'(dut.count), 32'd2);
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_data_ok = 1'b1;
      probe();
      check($sformatf("mid_ret%0d_data_ok", i),
            32'({inst_sram_data_ok, data_sram_data_ok}), 32'd0);
      next_cycle();
    end
    idle();
    probe();
    check("mid_final_count", 32'(dut.count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
